mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Parametrised multicycle MIPS control unit. It drives every control input of the multicycle datapath from an opcode-decoding FSM and replaces the hardwired constant control assignments in the CPU wrapper. Memory-access states use a `mem_ready` wait handshake with a configurable timeout. The block also provides an illegal-opcode trap and a retired-instruction counter.

## Interface
- `MEM_TIMEOUT`, default 15: maximum number of stall cycles allowed per memory state. 0 means wait forever.
- `CNT_W`, default 32: width of `instr_count`.
- `EN_ADDI`, default 1: 1 decodes ADDI (001000); 0 treats ADDI as an illegal opcode.
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  IR[31:26] from the datapath.
- `mem_ready`  in  1  memory completes its access this cycle.
- `ALUOp`, `ALUSrcB`, `PCSource`  out  2 each  datapath control.
- `RegDst`, `MemtoReg`, `MemRead`, `MemWrite`, `IorD`, `RegWrite`, `IRWrite`, `PCWrite`, `PCWriteCond`, `ALUSrcA`  out  1 each  datapath control.
- `state`  out  4  current FSM state, for debug.
- `instr_count`  out  CNT_W  number of retired instructions.
- `trap`  out  1  sticky; the FSM is halted.
- `mem_error`  out  1  sticky; the trap was caused by a memory timeout.

## Operation
- Supported opcodes: R-type 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, TRAP=12.
- Control outputs decoded per state. Every signal not listed below is 0.
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
  - MEMWR: MemWrite=1, IorD=1.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
  - TRAP: all control outputs 0.
- Transitions:
  - FETCH→DECODE when mem_ready=1.
  - DECODE branches on opcode: LW/SW→MEMADR, R→EXEC, BEQ→BRANCH, J→JUMP, ADDI (EN_ADDI=1)→ADDIEX, any other opcode→TRAP.
  - MEMADR→MEMRD (LW) or MEMWR (SW). Opcode is re-sampled here; the IR is stable.
  - MEMRD→MEMWB on mem_ready.
  - MEMWR→FETCH on mem_ready.
  - EXEC→ALUWB; ADDIEX→ADDIWB.
  - MEMWB, ALUWB, BRANCH, JUMP, ADDIWB→FETCH.
  - TRAP→TRAP until reset.
- Wait handshake (applies in FETCH, MEMRD, MEMWR):
  - The control outputs are held constant while mem_ready=0.
  - Stall counter `wcnt` is cleared on entry to each of these states and increments every cycle the FSM stays in the state with mem_ready=0.
  - With MEM_TIMEOUT>0: if mem_ready=0 while wcnt==MEM_TIMEOUT, next state is TRAP and mem_error is set.
- Retirement: instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, JUMP or ADDIWB. It wraps modulo 2^CNT_W. It never increments on a trap.
- trap=1 whenever state==TRAP.

## Timing
- Reset (reset_n=0, asynchronous):
  - state=FETCH, wcnt=0, instr_count=0, trap=0, mem_error=0.
  - Every control output is forced to 0 combinationally while reset_n=0, including MemRead in FETCH.
  - Reset asserted mid-instruction aborts it with no retirement. The first cycle after release is FETCH.
- All registers update on the rising edge of clock. Control outputs are Moore-decoded from `state`, except IRWrite/PCWrite in FETCH, which are also gated by mem_ready.
- Cycle counts with mem_ready tied to 1: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3. Each stall cycle adds 1.
- Timeout boundary with MEM_TIMEOUT=N:
  - mem_ready may arrive at the latest in cycle N of the state (cycle 0 = entry cycle) and the access still completes normally.
  - If mem_ready is still 0 in cycle N, the FSM enters TRAP on the next edge.
- mem_ready is ignored in all states other than FETCH, MEMRD and MEMWR.

## Test plan
- Reset state: reset_n=0 → all control outputs 0, state=0, instr_count=0. Release with mem_ready=1 → FETCH outputs MemRead=1, ALUSrcB=01, PCWrite=1, IRWrite=1.
- Opcode sequence R, LW, SW, BEQ, J, ADDI with mem_ready=1 → state sequences 0,1,6,7 / 0,1,2,3,4 / 0,1,2,5 / 0,1,8 / 0,1,9 / 0,1,10,11; instr_count=6 after the final ADDIWB.
- LW with mem_ready=0 for 3 cycles in MEMRD → state=3 held for 4 cycles with MemRead=1, IorD=1; then MEMWB; instr_count +1.
- MEM_TIMEOUT=2, SW with mem_ready=0 in MEMWR:
  - No mem_ready → TRAP after 3 cycles in MEMWR; trap=1, mem_error=1, all controls 0, no retirement.
  - Ready in cycle 2 of MEMWR → no trap.
- Opcode 111111, and ADDI with EN_ADDI=0 → DECODE→TRAP; mem_error=0; trap stays 1 until reset_n pulse.
- CNT_W=2: retire 5 R-type instructions → instr_count 1,2,3,0,1. Assert reset_n=0 mid-EXEC → state=0, count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
// Control/datapath bundle for the multicycle MIPS control unit.
// master = control unit, slave = datapath side (drives opcode and mem_ready).
interface mips_multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic [1:0]       ALUOp;
  logic [1:0]       ALUSrcB;
  logic [1:0]       PCSource;
  logic             RegDst;
  logic             MemtoReg;
  logic             MemRead;
  logic             MemWrite;
  logic             IorD;
  logic             RegWrite;
  logic             IRWrite;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             ALUSrcA;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;
  logic             trap;
  logic             mem_error;

  modport master (
    input  opcode, mem_ready,
    output ALUOp, ALUSrcB, PCSource, RegDst, MemtoReg, MemRead, MemWrite, IorD,
           RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA,
           state, instr_count, trap, mem_error
  );

  modport slave (
    output opcode, mem_ready,
    input  ALUOp, ALUSrcB, PCSource, RegDst, MemtoReg, MemRead, MemWrite, IorD,
           RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA,
           state, instr_count, trap, mem_error
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM with mem_ready wait states, memory timeout,
// illegal-opcode trap and a retired-instruction counter.
module mips_multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32,
  parameter int EN_ADDI     = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  mips_multicycle_control_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  // Stall counter only needs to reach MEM_TIMEOUT; it saturates beyond that.
  localparam int                 WCNT_W    = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0]  W_TIMEOUT = WCNT_W'(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0]  W_MAX     = {WCNT_W{1'b1}};

  state_t             r_state;
  state_t             w_next_base;
  state_t             w_next;
  state_t             w_dec_state;
  logic [WCNT_W-1:0]  r_wcnt;
  logic [CNT_W-1:0]   r_instr_count;
  logic               r_mem_error;
  logic               w_wait;
  logic               w_timeout;
  logic               w_retire;

  always_comb begin
    w_next_base = r_state;
    case (r_state)
      FETCH:  w_next_base = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: w_next_base = MEMADR;
          OP_R:         w_next_base = EXEC;
          OP_BEQ:       w_next_base = BRANCH;
          OP_J:         w_next_base = JUMP;
          OP_ADDI:      w_next_base = (EN_ADDI != 0) ? ADDIEX : TRAP;
          default:      w_next_base = TRAP;
        endcase
      end
      MEMADR: begin
        case (bus.opcode)
          OP_LW:   w_next_base = MEMRD;
          OP_SW:   w_next_base = MEMWR;
          default: w_next_base = TRAP;
        endcase
      end
      MEMRD:  w_next_base = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR:  w_next_base = bus.mem_ready ? FETCH : MEMWR;
      EXEC:   w_next_base = ALUWB;
      ADDIEX: w_next_base = ADDIWB;
      MEMWB, ALUWB, BRANCH, JUMP, ADDIWB: w_next_base = FETCH;
      TRAP:   w_next_base = TRAP;
      default: w_next_base = TRAP;
    endcase

    w_wait    = (r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR);
    w_timeout = (MEM_TIMEOUT > 0) && w_wait && !bus.mem_ready && (r_wcnt == W_TIMEOUT);
    w_next    = w_timeout ? TRAP : w_next_base;
    // FETCH only re-enters itself by stalling, so any arrival there retires.
    w_retire  = (w_next == FETCH) && (r_state != FETCH);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= FETCH;
      r_wcnt        <= {WCNT_W{1'b0}};
      r_instr_count <= {CNT_W{1'b0}};
      r_mem_error   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_wcnt <= {WCNT_W{1'b0}};
      end else if (w_wait && !bus.mem_ready && (r_wcnt != W_MAX)) begin
        r_wcnt <= r_wcnt + WCNT_W'(1);
      end else begin
        r_wcnt <= r_wcnt;
      end
      if (w_retire) begin
        r_instr_count <= r_instr_count + CNT_W'(1);
      end else begin
        r_instr_count <= r_instr_count;
      end
      if (w_timeout) begin
        r_mem_error <= 1'b1;
      end else begin
        r_mem_error <= r_mem_error;
      end
    end
  end

  // Decoding TRAP while reset_n is low forces every control to 0 immediately.
  always_comb begin
    w_dec_state     = reset_n ? r_state : TRAP;
    bus.ALUOp       = 2'b00;
    bus.ALUSrcB     = 2'b00;
    bus.PCSource    = 2'b00;
    bus.RegDst      = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IorD        = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.ALUSrcA     = 1'b0;
    case (w_dec_state)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      DECODE: bus.ALUSrcB = 2'b11;
      MEMADR, ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      MEMWB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
      end
      MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      ALUWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
      end
      JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
      ADDIWB: bus.RegWrite = 1'b1;
      TRAP:   bus.RegWrite = 1'b0;
      default: bus.RegWrite = 1'b0;
    endcase
  end

  assign bus.state       = r_state;
  assign bus.trap        = (r_state == TRAP);
  assign bus.instr_count = r_instr_count;
  assign bus.mem_error   = r_mem_error;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench: a default-parameter instance (A) and a small instance (B:
// MEM_TIMEOUT=2, CNT_W=2, EN_ADDI=0), directed vectors plus a randomized model run.
module tb_mips_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  st;
    logic [31:0] cnt;
  } vec_t;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   n_checks;
  int   n_err;
  vec_t tab[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mips_multicycle_control_if #(.CNT_W(32)) if_a();
  mips_multicycle_control_if #(.CNT_W(2))  if_b();

  mips_multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(32), .EN_ADDI(1)) dut_a (
    .clock(clk), .reset_n(rst_a), .bus(if_a)
  );
  mips_multicycle_control #(.MEM_TIMEOUT(2), .CNT_W(2), .EN_ADDI(0)) dut_b (
    .clock(clk), .reset_n(rst_b), .bus(if_b)
  );

  logic [15:0] a_ctrl;
  logic [15:0] b_ctrl;
  logic [53:0] obs_a;
  logic [53:0] obs_b;
  assign a_ctrl = {if_a.ALUOp, if_a.ALUSrcB, if_a.PCSource, if_a.RegDst, if_a.MemtoReg,
                   if_a.MemRead, if_a.MemWrite, if_a.IorD, if_a.RegWrite, if_a.IRWrite,
                   if_a.PCWrite, if_a.PCWriteCond, if_a.ALUSrcA};
  assign b_ctrl = {if_b.ALUOp, if_b.ALUSrcB, if_b.PCSource, if_b.RegDst, if_b.MemtoReg,
                   if_b.MemRead, if_b.MemWrite, if_b.IorD, if_b.RegWrite, if_b.IRWrite,
                   if_b.PCWrite, if_b.PCWriteCond, if_b.ALUSrcA};
  assign obs_a = {if_a.trap, if_a.mem_error, if_a.state, a_ctrl, if_a.instr_count};
  assign obs_b = {if_b.trap, if_b.mem_error, if_b.state, b_ctrl, 30'd0, if_b.instr_count};

  // Control table: {ALUOp,ALUSrcB,PCSource,RegDst,MemtoReg,MemRead,MemWrite,IorD,RegWrite,IRWrite,PCWrite,PCWriteCond,ALUSrcA}
  function automatic logic [15:0] ctrl_of(input logic [3:0] st, input logic mr);
    case (st)
      4'd0:    ctrl_of = 16'b00_01_00_0_0_1_0_0_0_0_0_0_0 | (mr ? 16'b0000_0000_0000_1100 : 16'd0);
      4'd1:    ctrl_of = 16'b00_11_00_0_0_0_0_0_0_0_0_0_0;
      4'd2:    ctrl_of = 16'b00_10_00_0_0_0_0_0_0_0_0_0_1;
      4'd3:    ctrl_of = 16'b00_00_00_0_0_1_0_1_0_0_0_0_0;
      4'd4:    ctrl_of = 16'b00_00_00_0_1_0_0_0_1_0_0_0_0;
      4'd5:    ctrl_of = 16'b00_00_00_0_0_0_1_1_0_0_0_0_0;
      4'd6:    ctrl_of = 16'b10_00_00_0_0_0_0_0_0_0_0_0_1;
      4'd7:    ctrl_of = 16'b00_00_00_1_0_0_0_0_1_0_0_0_0;
      4'd8:    ctrl_of = 16'b01_00_01_0_0_0_0_0_0_0_0_1_1;
      4'd9:    ctrl_of = 16'b00_00_10_0_0_0_0_0_0_0_1_0_0;
      4'd10:   ctrl_of = 16'b00_10_00_0_0_0_0_0_0_0_0_0_1;
      4'd11:   ctrl_of = 16'b00_00_00_0_0_0_0_0_1_0_0_0_0;
      default: ctrl_of = 16'd0;
    endcase
  endfunction

  function automatic logic [53:0] mk_exp(input logic [3:0] st, input logic mr, input logic rn,
                                         input logic [31:0] cnt, input logic err);
    mk_exp = {(st == 4'd12), err, st, (rn ? ctrl_of(st, mr) : 16'd0), cnt};
  endfunction

  task automatic chk(input int sel, input string nm, input logic [53:0] exp);
    logic [53:0] act;
    act = (sel == 0) ? obs_a : obs_b;
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (dut %0d): got trap=%0b err=%0b state=%0d ctrl=%h cnt=%0d, expected trap=%0b err=%0b state=%0d ctrl=%h cnt=%0d",
               nm, sel, act[53], act[52], act[51:48], act[47:32], act[31:0],
               exp[53], exp[52], exp[51:48], exp[47:32], exp[31:0]);
    end
  endtask

  task automatic drive(input int sel, input logic [5:0] op, input logic mr);
    if (sel == 0) begin
      if_a.opcode = op; if_a.mem_ready = mr;
    end else begin
      if_b.opcode = op; if_b.mem_ready = mr;
    end
  endtask

  task automatic set_rst(input int sel, input logic v);
    if (sel == 0) rst_a = v;
    else rst_b = v;
  endtask

  // Starts and ends at a falling edge: drive, check, advance one cycle.
  task automatic cyc(input int sel, input logic [5:0] op, input logic mr, input logic [3:0] st,
                     input logic [31:0] cnt, input logic err, input string nm);
    drive(sel, op, mr);
    #1;
    chk(sel, nm, mk_exp(st, mr, 1'b1, cnt, err));
    @(negedge clk);
  endtask

  task automatic do_reset(input int sel);
    set_rst(sel, 1'b0);
    drive(sel, OP_R, 1'b1);
    #1;
    chk(sel, "reset_state", mk_exp(4'd0, 1'b1, 1'b0, 32'd0, 1'b0));
    @(negedge clk);
    set_rst(sel, 1'b1);
  endtask

  // Reference model: each opcode is a fixed path of states; wait states consume mem_ready.
  task automatic rand_run(input int sel, input int ncyc, input int tmo, input logic [31:0] mask,
                          input bit en_addi);
    int          p[5];
    int          plen, idx, stall, trap_cyc, r;
    logic [31:0] cnt;
    logic        err, mr;
    bit          trapped;
    logic [5:0]  op;
    logic [3:0]  cur;
    idx = 0; stall = 0; cnt = 32'd0; err = 1'b0; trapped = 1'b0; trap_cyc = 0;
    plen = 1; p = '{0, 0, 0, 0, 0}; op = OP_R;
    for (int c = 0; c < ncyc; c++) begin
      if (trapped && trap_cyc >= 2) begin
        do_reset(sel);
        idx = 0; stall = 0; cnt = 32'd0; err = 1'b0; trapped = 1'b0; trap_cyc = 0;
      end
      if (!trapped && idx == 0 && stall == 0) begin
        r = $urandom_range(0, 12);
        if (r < 2)       op = OP_R;
        else if (r < 4)  op = OP_LW;
        else if (r < 6)  op = OP_SW;
        else if (r < 8)  op = OP_BEQ;
        else if (r < 10) op = OP_J;
        else if (r < 12) op = OP_ADDI;
        else             op = (r[0]) ? OP_BAD : OP_JAL;
        case (op)
          OP_R:    begin p = '{0, 1, 6, 7, 0};  plen = 4; end
          OP_LW:   begin p = '{0, 1, 2, 3, 4};  plen = 5; end
          OP_SW:   begin p = '{0, 1, 2, 5, 0};  plen = 4; end
          OP_BEQ:  begin p = '{0, 1, 8, 0, 0};  plen = 3; end
          OP_J:    begin p = '{0, 1, 9, 0, 0};  plen = 3; end
          OP_ADDI: begin
            if (en_addi) begin p = '{0, 1, 10, 11, 0}; plen = 4; end
            else begin p = '{0, 1, 12, 0, 0}; plen = 3; end
          end
          default: begin p = '{0, 1, 12, 0, 0}; plen = 3; end
        endcase
      end
      cur = trapped ? 4'd12 : 4'(p[idx]);
      mr  = ($urandom_range(0, 2) != 0);
      if (tmo > 8 && stall >= 8) mr = 1'b1;
      drive(sel, op, mr);
      #1;
      chk(sel, "random", mk_exp(cur, mr, 1'b1, cnt, err));
      if (trapped) begin
        trap_cyc++;
      end else if ((cur == 4'd0 || cur == 4'd3 || cur == 4'd5) && !mr) begin
        if (tmo > 0 && stall == tmo) begin
          trapped = 1'b1; err = 1'b1;
        end else begin
          stall++;
        end
      end else begin
        stall = 0;
        idx++;
        if (idx == plen) begin
          idx = 0;
          cnt = (cnt + 32'd1) & mask;
        end else if (p[idx] == 12) begin
          trapped = 1'b1;
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0; n_err = 0;
    rst_a = 1'b0; rst_b = 1'b0;
    drive(0, OP_R, 1'b1);
    drive(1, OP_R, 1'b1);

    tab.push_back('{OP_R,    4'd0,  32'd0});
    tab.push_back('{OP_R,    4'd1,  32'd0});
    tab.push_back('{OP_R,    4'd6,  32'd0});
    tab.push_back('{OP_R,    4'd7,  32'd0});
    tab.push_back('{OP_LW,   4'd0,  32'd1});
    tab.push_back('{OP_LW,   4'd1,  32'd1});
    tab.push_back('{OP_LW,   4'd2,  32'd1});
    tab.push_back('{OP_LW,   4'd3,  32'd1});
    tab.push_back('{OP_LW,   4'd4,  32'd1});
    tab.push_back('{OP_SW,   4'd0,  32'd2});
    tab.push_back('{OP_SW,   4'd1,  32'd2});
    tab.push_back('{OP_SW,   4'd2,  32'd2});
    tab.push_back('{OP_SW,   4'd5,  32'd2});
    tab.push_back('{OP_BEQ,  4'd0,  32'd3});
    tab.push_back('{OP_BEQ,  4'd1,  32'd3});
    tab.push_back('{OP_BEQ,  4'd8,  32'd3});
    tab.push_back('{OP_J,    4'd0,  32'd4});
    tab.push_back('{OP_J,    4'd1,  32'd4});
    tab.push_back('{OP_J,    4'd9,  32'd4});
    tab.push_back('{OP_ADDI, 4'd0,  32'd5});
    tab.push_back('{OP_ADDI, 4'd1,  32'd5});
    tab.push_back('{OP_ADDI, 4'd10, 32'd5});
    tab.push_back('{OP_ADDI, 4'd11, 32'd5});
    tab.push_back('{OP_R,    4'd0,  32'd6});

    @(negedge clk);
    do_reset(1);
    do_reset(0);

    // Instruction mix with mem_ready tied high
    for (int i = 0; i < tab.size(); i++) begin
      cyc(0, tab[i].op, 1'b1, tab[i].st, tab[i].cnt, 1'b0, "table");
    end

    // LW with three stall cycles in MEMRD
    cyc(0, OP_LW, 1'b1, 4'd1, 32'd6, 1'b0, "lw_stall_dec");
    cyc(0, OP_LW, 1'b1, 4'd2, 32'd6, 1'b0, "lw_stall_adr");
    for (int i = 0; i < 3; i++) cyc(0, OP_LW, 1'b0, 4'd3, 32'd6, 1'b0, "lw_stall_wait");
    cyc(0, OP_LW, 1'b1, 4'd3, 32'd6, 1'b0, "lw_stall_done");
    cyc(0, OP_LW, 1'b1, 4'd4, 32'd6, 1'b0, "lw_stall_wb");
    cyc(0, OP_R,  1'b1, 4'd0, 32'd7, 1'b0, "lw_stall_retire");

    // Illegal opcode traps from DECODE without mem_error
    cyc(0, OP_BAD, 1'b1, 4'd1,  32'd7, 1'b0, "bad_dec");
    cyc(0, OP_BAD, 1'b1, 4'd12, 32'd7, 1'b0, "bad_trap");
    cyc(0, OP_BAD, 1'b0, 4'd12, 32'd7, 1'b0, "bad_trap_hold");
    cyc(0, OP_R,   1'b1, 4'd12, 32'd7, 1'b0, "bad_trap_hold2");
    do_reset(0);
    cyc(0, OP_R, 1'b1, 4'd0, 32'd0, 1'b0, "bad_after_reset");

    // SW memory timeout on the MEM_TIMEOUT=2 instance
    do_reset(1);
    cyc(1, OP_SW, 1'b1, 4'd0, 32'd0, 1'b0, "to_fetch");
    cyc(1, OP_SW, 1'b1, 4'd1, 32'd0, 1'b0, "to_dec");
    cyc(1, OP_SW, 1'b1, 4'd2, 32'd0, 1'b0, "to_adr");
    for (int i = 0; i < 3; i++) cyc(1, OP_SW, 1'b0, 4'd5, 32'd0, 1'b0, "to_wait");
    cyc(1, OP_SW, 1'b0, 4'd12, 32'd0, 1'b1, "to_trap");
    cyc(1, OP_SW, 1'b1, 4'd12, 32'd0, 1'b1, "to_trap_hold");

    // mem_ready at the last allowed cycle still completes
    do_reset(1);
    cyc(1, OP_SW, 1'b1, 4'd0, 32'd0, 1'b0, "late_fetch");
    cyc(1, OP_SW, 1'b1, 4'd1, 32'd0, 1'b0, "late_dec");
    cyc(1, OP_SW, 1'b1, 4'd2, 32'd0, 1'b0, "late_adr");
    cyc(1, OP_SW, 1'b0, 4'd5, 32'd0, 1'b0, "late_wait0");
    cyc(1, OP_SW, 1'b0, 4'd5, 32'd0, 1'b0, "late_wait1");
    cyc(1, OP_SW, 1'b1, 4'd5, 32'd0, 1'b0, "late_ready2");
    cyc(1, OP_ADDI, 1'b1, 4'd0, 32'd1, 1'b0, "late_retire");

    // ADDI disabled on instance B
    cyc(1, OP_ADDI, 1'b1, 4'd1,  32'd1, 1'b0, "addi_off_dec");
    cyc(1, OP_ADDI, 1'b1, 4'd12, 32'd1, 1'b0, "addi_off_trap");
    cyc(1, OP_ADDI, 1'b1, 4'd12, 32'd1, 1'b0, "addi_off_hold");

    // 2-bit counter wrap, then asynchronous reset mid-EXEC
    do_reset(1);
    for (int k = 0; k < 5; k++) begin
      cyc(1, OP_R, 1'b1, 4'd0, 32'(k & 3), 1'b0, "wrap_fetch");
      cyc(1, OP_R, 1'b1, 4'd1, 32'(k & 3), 1'b0, "wrap_dec");
      cyc(1, OP_R, 1'b1, 4'd6, 32'(k & 3), 1'b0, "wrap_exec");
      cyc(1, OP_R, 1'b1, 4'd7, 32'(k & 3), 1'b0, "wrap_wb");
    end
    cyc(1, OP_R, 1'b1, 4'd0, 32'd1, 1'b0, "wrap_final");
    cyc(1, OP_R, 1'b1, 4'd1, 32'd1, 1'b0, "wrap_dec2");
    drive(1, OP_R, 1'b1);
    #1;
    chk(1, "exec_before_reset", mk_exp(4'd6, 1'b1, 1'b1, 32'd1, 1'b0));
    rst_b = 1'b0;
    #1;
    chk(1, "async_reset", mk_exp(4'd0, 1'b1, 1'b0, 32'd0, 1'b0));
    @(negedge clk);
    rst_b = 1'b1;
    cyc(1, OP_R, 1'b1, 4'd0, 32'd0, 1'b0, "post_async_reset");

    // Randomized runs against the path model
    do_reset(0);
    rand_run(0, 3000, 15, 32'hFFFF_FFFF, 1'b1);
    do_reset(1);
    rand_run(1, 3000, 2, 32'h0000_0003, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
